// File: rtl/button_debounce_sync.sv
// button_debounce_sync: two-flop synchronizer plus counting debounce FSM with registered press/release strobes and press counter
module button_debounce_sync #(
    parameter int DB_COUNT = 500000,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             RST_N,
    input  logic             BTN_IN,
    output logic             BTN_CLEAN,
    output logic             PRESS_PULSE,
    output logic             RELEASE_PULSE,
    output logic [CNT_W-1:0] PRESS_COUNT
);
    localparam int CW = $clog2(DB_COUNT + 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] INC = CNT_W'(1);

    typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;

    state_t        state;
    logic          sync1;
    logic          s;
    logic [CW-1:0] cnt;

    // bring the asynchronous pin into the clk domain
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= BTN_IN;
            s     <= sync1;
        end
    end

    // debounce FSM: a level is accepted only after DB_COUNT consecutive samples of s
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            state         <= IDLE_LOW;
            cnt           <= '0;
            BTN_CLEAN     <= 1'b0;
            PRESS_PULSE   <= 1'b0;
            RELEASE_PULSE <= 1'b0;
            PRESS_COUNT   <= '0;
        end else begin
            PRESS_PULSE   <= 1'b0;
            RELEASE_PULSE <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (s && DB_COUNT == 1) begin
                        state       <= IDLE_HIGH;
                        cnt         <= '0;
                        BTN_CLEAN   <= 1'b1;
                        PRESS_PULSE <= 1'b1;
                        PRESS_COUNT <= PRESS_COUNT + INC;
                    end else if (s) begin
                        state <= WAIT_HIGH;
                        cnt   <= ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state       <= IDLE_HIGH;
                        cnt         <= '0;
                        BTN_CLEAN   <= 1'b1;
                        PRESS_PULSE <= 1'b1;
                        PRESS_COUNT <= PRESS_COUNT + INC;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!s && DB_COUNT == 1) begin
                        state         <= IDLE_LOW;
                        cnt           <= '0;
                        BTN_CLEAN     <= 1'b0;
                        RELEASE_PULSE <= 1'b1;
                    end else if (!s) begin
                        state <= WAIT_LOW;
                        cnt   <= ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state         <= IDLE_LOW;
                        cnt           <= '0;
                        BTN_CLEAN     <= 1'b0;
                        RELEASE_PULSE <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/button_debounce_sync.md
Name: button_debounce_sync

Overview:
- Conditions a raw, bouncing Basys board pushbutton into a clean, single-clock-domain level (BTN_CLEAN).
- BTN_CLEAN drives the REG_LD input of the interrupt pulse generator directly. That stage needs a level that stays high for the whole press and drops once on release.
- Also provides one-cycle press and release strobes plus a wrapping press counter for LED/debug display.

Parameters:
- DB_COUNT, 500000, number of consecutive synchronized clk samples at the new level needed to accept a transition; legal range >= 1.
- CNT_W, 8, width of PRESS_COUNT.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- BTN_IN  input  1  raw asynchronous button from the board pin.
- BTN_CLEAN  output  1  debounced level; feeds REG_LD of the interrupt pulse generator.
- PRESS_PULSE  output  1  one-cycle strobe on accepted low->high transition.
- RELEASE_PULSE  output  1  one-cycle strobe on accepted high->low transition.
- PRESS_COUNT  output  CNT_W  count of accepted presses, modulo 2^CNT_W.

Behaviour:
Reset:
- RST_N=0 at a rising edge: sync flops <= 0, debounce counter <= 0, state <= IDLE_LOW.
- Also at that edge: BTN_CLEAN, PRESS_PULSE, RELEASE_PULSE <= 0 and PRESS_COUNT <= 0.
- Reset overrides all other activity, including mid-debounce; any partial count is discarded.

Synchronizer:
- Two-flop chain sync1 <= BTN_IN, then s <= sync1.
- The FSM reads only s, never BTN_IN.

Debounce counter:
- Width $clog2(DB_COUNT+1).
- Counts consecutive samples of s at the candidate level.

FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. All transitions below occur at the rising edge.
- IDLE_LOW (BTN_CLEAN=0):
  - s=1 and DB_COUNT=1: go to IDLE_HIGH.
  - s=1 and DB_COUNT>1: go to WAIT_HIGH, cnt<=1.
  - Otherwise stay, cnt<=0.
- WAIT_HIGH:
  - s=0: go to IDLE_LOW, cnt<=0, no output change (glitch rejected).
  - s=1 and cnt==DB_COUNT-1: go to IDLE_HIGH.
  - Otherwise cnt<=cnt+1.
- Entering IDLE_HIGH:
  - BTN_CLEAN<=1 and PRESS_PULSE<=1 for exactly one cycle.
  - PRESS_COUNT<=PRESS_COUNT+1, wrapping all-ones -> 0.
- IDLE_HIGH / WAIT_LOW are symmetric to IDLE_LOW / WAIT_HIGH with s inverted.
- Entering IDLE_LOW from WAIT_LOW (or directly when DB_COUNT=1):
  - BTN_CLEAN<=0 and RELEASE_PULSE<=1 for one cycle.
  - PRESS_COUNT unchanged.

Latency:
- A stable BTN_IN edge first sampled at edge 0 appears on BTN_CLEAN after edge DB_COUNT+1, i.e. DB_COUNT+2 edges in total.
- That total is 2 synchronizer edges plus DB_COUNT accepted samples.

Output and timing rules:
- All outputs are registered; there are no combinational paths from BTN_IN.
- PRESS_PULSE and RELEASE_PULSE are never high in the same cycle.
- Each strobe is high for at most 1 cycle per accepted transition.
- Minimum BTN_CLEAN high or low dwell is DB_COUNT cycles.
- Button already held when RST_N releases: the sync flops start at 0, so the press is debounced normally and produces one PRESS_PULSE DB_COUNT+2 edges later.
- Bounce train where no run of s reaches DB_COUNT: no output activity at all.

Test Plan:
- DB_COUNT=4; clean press: BTN_IN 0->1 at edge 0, held -> BTN_CLEAN=1 and PRESS_PULSE=1 after edge 5; PRESS_PULSE=0 after edge 6; PRESS_COUNT=1.
- DB_COUNT=4; bounce: BTN_IN high 3 cycles, low 1, high 3, low -> BTN_CLEAN stays 0, no strobes, PRESS_COUNT=0.
- DB_COUNT=4; release after clean press: BTN_IN 1->0 held -> BTN_CLEAN=0 and RELEASE_PULSE=1 for one cycle, 6 edges after the drop; PRESS_COUNT still 1.
- DB_COUNT=4, CNT_W=8; 256 clean press/release cycles -> PRESS_COUNT returns to 0; exactly 256 PRESS_PULSE and 256 RELEASE_PULSE.
- DB_COUNT=4; RST_N=0 for one edge while in WAIT_HIGH with cnt=2 -> all outputs 0, state IDLE_LOW. BTN_IN still high, so the press is accepted 6 edges after reset release.
- DB_COUNT=1; BTN_IN 0->1 -> BTN_CLEAN=1 after edge 2. A single-cycle low glitch on BTN_IN produces exactly one release and one press, each strobe 1 cycle.
